axis_pcie_tx_elastic_pipe: RTL and testbench

//  Parametrised AXIS PCIe TX elastic buffer; generalises the single-register TX pipeline.

---
 rtl/axis_pcie_tx_elastic_pipe.sv | 174 +++++++++++++++++
 tb/tb_axis_pcie_tx_elastic_pipe.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_pcie_tx_elastic_pipe.sv
// AXI-Stream elastic stage between the TX arbiter and the PCIe HIP TX bridge.
// MODE 0 is a skid register, MODE 1 a store-and-forward packet FIFO, MODE 2 a wire bypass.
module axis_pcie_tx_elastic_pipe #(
  parameter int unsigned TDATA_WIDTH    = 512,
  parameter int unsigned TUSER_WIDTH    = 10,
  parameter int unsigned DEPTH          = 8,
  parameter int unsigned MODE           = 0,
  parameter int unsigned AF_THRESH      = 6,
  parameter bit          TREADY_RST_VAL = 1'b0
) (
  input  logic                       s_if_clk,
  input  logic                       s_if_rst_n,
  input  logic                       s_if_tvalid,
  input  logic [TDATA_WIDTH-1:0]     s_if_tdata,
  input  logic                       s_if_tlast,
  input  logic [TUSER_WIDTH-1:0]     s_if_tuser,
  output logic                       s_if_tready,
  output logic                       m_if_tvalid,
  output logic [TDATA_WIDTH-1:0]     m_if_tdata,
  output logic                       m_if_tlast,
  output logic [TUSER_WIDTH-1:0]     m_if_tuser,
  input  logic                       m_if_tready,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic                       almost_full,
  output logic [$clog2(DEPTH):0]     pkt_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned BW = TDATA_WIDTH + TUSER_WIDTH + 1;
  localparam logic [CW-1:0] AF_LVL    = CW'(AF_THRESH);
  localparam logic [CW-1:0] DEPTH_LVL = CW'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_err_depth
    $error("axis_pcie_tx_elastic_pipe: DEPTH must be a power of 2 and >= 2");
  end
  if (AF_THRESH > DEPTH) begin : g_err_af
    $error("axis_pcie_tx_elastic_pipe: AF_THRESH exceeds DEPTH");
  end
  if (MODE > 2) begin : g_err_mode
    $error("axis_pcie_tx_elastic_pipe: MODE must be 0, 1 or 2");
  end

  logic [BW-1:0] s_beat;
  assign s_beat = {s_if_tlast, s_if_tuser, s_if_tdata};

  if (MODE == 0) begin : g_skid
    logic [BW-1:0] main_q, main_d, skid_q, skid_d;
    logic          main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
    logic          rdy_q, in_fire;
    logic [CW-1:0] occ_q, occ_d, pkt_q, pkt_d;
    logic          af_q;

    assign in_fire = s_if_tvalid & rdy_q;

    always_comb begin
      main_d     = main_q;
      main_vld_d = main_vld_q;
      skid_d     = skid_q;
      skid_vld_d = skid_vld_q;
      if (!main_vld_q || m_if_tready) begin
        if (skid_vld_q) begin
          main_d     = skid_q;
          main_vld_d = 1'b1;
          skid_vld_d = 1'b0;
        end else begin
          main_vld_d = in_fire;
          if (in_fire) main_d = s_beat;
        end
      end else if (in_fire) begin
        // Downstream stalled: park the in-flight beat, ready drops next cycle.
        skid_d     = s_beat;
        skid_vld_d = 1'b1;
      end
    end

    assign occ_d = CW'(main_vld_d) + CW'(skid_vld_d);
    assign pkt_d = CW'(main_vld_d & main_d[BW-1]) + CW'(skid_vld_d & skid_d[BW-1]);

    always_ff @(posedge s_if_clk or negedge s_if_rst_n) begin
      if (!s_if_rst_n) begin
        main_vld_q <= 1'b0;
        skid_vld_q <= 1'b0;
        rdy_q      <= TREADY_RST_VAL;
        occ_q      <= '0;
        pkt_q      <= '0;
        af_q       <= 1'b0;
      end else begin
        main_vld_q <= main_vld_d;
        skid_vld_q <= skid_vld_d;
        rdy_q      <= ~skid_vld_d;
        occ_q      <= occ_d;
        pkt_q      <= pkt_d;
        af_q       <= (occ_d >= AF_LVL);
      end
    end

    always_ff @(posedge s_if_clk) begin
      main_q <= main_d;
      skid_q <= skid_d;
    end

    assign s_if_tready                          = rdy_q;
    assign m_if_tvalid                          = main_vld_q;
    assign {m_if_tlast, m_if_tuser, m_if_tdata} = main_q;
    assign occupancy                            = occ_q;
    assign pkt_cnt                              = pkt_q;
    assign almost_full                          = af_q;

  end else if (MODE == 1) begin : g_fifo
    logic [BW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] occ_q, occ_d, pkt_q, pkt_d;
    logic          rdy_q, af_q, cut_q, cut_d;
    logic          wr, rd, m_vld, rd_last;
    logic [BW-1:0] rd_beat;

    assign rd_beat = mem[rd_ptr_q];
    assign rd_last = rd_beat[BW-1];
    // A full FIFO with no complete TLP is a TLP longer than DEPTH: start cutting through.
    assign m_vld   = (occ_q != '0) && ((pkt_q != '0) || (occ_q == DEPTH_LVL) || cut_q);
    assign wr      = s_if_tvalid & rdy_q;
    assign rd      = m_vld & m_if_tready;

    always_comb begin
      occ_d = occ_q + CW'(wr) - CW'(rd);
      pkt_d = pkt_q + CW'(wr & s_if_tlast) - CW'(rd & rd_last);
      cut_d = cut_q;
      if (rd) cut_d = rd_last ? 1'b0 : (cut_q | (pkt_q == '0));
    end

    always_ff @(posedge s_if_clk or negedge s_if_rst_n) begin
      if (!s_if_rst_n) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        occ_q    <= '0;
        pkt_q    <= '0;
        cut_q    <= 1'b0;
        rdy_q    <= TREADY_RST_VAL;
        af_q     <= 1'b0;
      end else begin
        if (wr) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (rd) rd_ptr_q <= rd_ptr_q + AW'(1);
        occ_q <= occ_d;
        pkt_q <= pkt_d;
        cut_q <= cut_d;
        rdy_q <= (occ_d < DEPTH_LVL);
        af_q  <= (occ_d >= AF_LVL);
      end
    end

    always_ff @(posedge s_if_clk) begin
      if (wr) mem[wr_ptr_q] <= s_beat;
    end

    assign s_if_tready                          = rdy_q;
    assign m_if_tvalid                          = m_vld;
    assign {m_if_tlast, m_if_tuser, m_if_tdata} = rd_beat;
    assign occupancy                            = occ_q;
    assign pkt_cnt                              = pkt_q;
    assign almost_full                          = af_q;

  end else begin : g_bypass
    assign s_if_tready = m_if_tready;
    assign m_if_tvalid = s_if_tvalid;
    assign m_if_tdata  = s_if_tdata;
    assign m_if_tlast  = s_if_tlast;
    assign m_if_tuser  = s_if_tuser;
    assign occupancy   = '0;
    assign pkt_cnt     = '0;
    assign almost_full = 1'b0;
  end

endmodule

// File: tb/tb_axis_pcie_tx_elastic_pipe.sv
// Directed bench for the skid (MODE 0), packet FIFO (MODE 1) and bypass (MODE 2) variants.
module tb_axis_pcie_tx_elastic_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic        rst0, rst1, rst2;
  logic        sv0, sl0, sr0, mv0, ml0, mr0, af0;
  logic [31:0] sd0, md0;
  logic [9:0]  su0, mu0;
  logic [3:0]  occ0, pc0;
  logic        sv1, sl1, sr1, mv1, ml1, mr1, af1;
  logic [31:0] sd1, md1;
  logic [9:0]  su1, mu1;
  logic [3:0]  occ1, pc1;
  logic        sv2, sl2, sr2, mv2, ml2, mr2, af2;
  logic [31:0] sd2, md2;
  logic [9:0]  su2, mu2;
  logic [3:0]  occ2, pc2;

  axis_pcie_tx_elastic_pipe #(.TDATA_WIDTH(32), .TUSER_WIDTH(10), .DEPTH(8), .MODE(0),
    .AF_THRESH(6), .TREADY_RST_VAL(1'b0)) u_skid (
    .s_if_clk(clk), .s_if_rst_n(rst0), .s_if_tvalid(sv0), .s_if_tdata(sd0), .s_if_tlast(sl0),
    .s_if_tuser(su0), .s_if_tready(sr0), .m_if_tvalid(mv0), .m_if_tdata(md0), .m_if_tlast(ml0),
    .m_if_tuser(mu0), .m_if_tready(mr0), .occupancy(occ0), .almost_full(af0), .pkt_cnt(pc0));

  axis_pcie_tx_elastic_pipe #(.TDATA_WIDTH(32), .TUSER_WIDTH(10), .DEPTH(8), .MODE(1),
    .AF_THRESH(6), .TREADY_RST_VAL(1'b0)) u_fifo (
    .s_if_clk(clk), .s_if_rst_n(rst1), .s_if_tvalid(sv1), .s_if_tdata(sd1), .s_if_tlast(sl1),
    .s_if_tuser(su1), .s_if_tready(sr1), .m_if_tvalid(mv1), .m_if_tdata(md1), .m_if_tlast(ml1),
    .m_if_tuser(mu1), .m_if_tready(mr1), .occupancy(occ1), .almost_full(af1), .pkt_cnt(pc1));

  axis_pcie_tx_elastic_pipe #(.TDATA_WIDTH(32), .TUSER_WIDTH(10), .DEPTH(8), .MODE(2),
    .AF_THRESH(6), .TREADY_RST_VAL(1'b0)) u_byp (
    .s_if_clk(clk), .s_if_rst_n(rst2), .s_if_tvalid(sv2), .s_if_tdata(sd2), .s_if_tlast(sl2),
    .s_if_tuser(su2), .s_if_tready(sr2), .m_if_tvalid(mv2), .m_if_tdata(md2), .m_if_tlast(ml2),
    .m_if_tuser(mu2), .m_if_tready(mr2), .occupancy(occ2), .almost_full(af2), .pkt_cnt(pc2));

  // Output collectors: inputs change only just after posedge, so the negedge view is the handshake.
  logic [31:0] q0d[$], q1d[$];
  logic        q0l[$], q1l[$];
  always @(negedge clk) begin
    if (mv0 && mr0) begin q0d.push_back(md0); q0l.push_back(ml0); end
    if (mv1 && mr1) begin q1d.push_back(md1); q1l.push_back(ml1); end
  end

  task automatic put0(input logic [31:0] d, input logic l);
    int n = 0;
    sv0 = 1'b1; sd0 = d; sl0 = l; su0 = d[9:0];
    @(negedge clk);
    while (!sr0 && n < 100) begin n++; @(negedge clk); end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL put0_timeout data=%h ready never seen", d);
    end
    @(posedge clk); #1;
    sv0 = 1'b0;
  endtask

  task automatic put1(input logic [31:0] d, input logic l);
    int n = 0;
    sv1 = 1'b1; sd1 = d; sl1 = l; su1 = d[9:0];
    @(negedge clk);
    while (!sr1 && n < 100) begin n++; @(negedge clk); end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL put1_timeout data=%h ready never seen", d);
    end
    @(posedge clk); #1;
    sv1 = 1'b0;
  endtask

  task automatic wait_q1(input int cnt);
    int n = 0;
    while (q1d.size() < cnt && n < 60) begin @(posedge clk); n++; end
    #1;
  endtask

  task automatic test_reset();
    rst0 = 0; rst1 = 0; rst2 = 0;
    {sv0, sl0, mr0, sv1, sl1, mr1, sv2, sl2, mr2} = '0;
    sd0 = '0; su0 = '0; sd1 = '0; su1 = '0; sd2 = '0; su2 = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (mv0 !== 1'b0) begin errors++; $display("FAIL rst_mvalid0 got=%b want=0", mv0); end
    checks++; if (occ0 !== 4'd0) begin errors++; $display("FAIL rst_occ0 got=%0d want=0", occ0); end
    checks++; if (sr0 !== 1'b0) begin errors++; $display("FAIL rst_sready0 got=%b want=0", sr0); end
    checks++; if (mv1 !== 1'b0) begin errors++; $display("FAIL rst_mvalid1 got=%b want=0", mv1); end
    checks++; if ({occ1, pc1, af1} !== 9'd0)
      begin errors++; $display("FAIL rst_stat1 got=%0d/%0d/%b want=0/0/0", occ1, pc1, af1); end
    checks++; if (sr1 !== 1'b0) begin errors++; $display("FAIL rst_sready1 got=%b want=0", sr1); end
    rst0 = 1; rst1 = 1; rst2 = 1;
    @(posedge clk); #1;
    checks++; if (sr0 !== 1'b1) begin errors++; $display("FAIL rel_sready0 got=%b want=1", sr0); end
    checks++; if (sr1 !== 1'b1) begin errors++; $display("FAIL rel_sready1 got=%b want=1", sr1); end
  endtask

  task automatic test_skid_stream();
    q0d.delete(); q0l.delete();
    mr0 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      put0(32'h100 + i, i == 15);
      checks++;
      if (mv0 !== 1'b1 || md0 !== 32'h100 + i)
        begin errors++; $display("FAIL skid_latency beat=%0d got=%b/%h want=1/%h", i, mv0, md0,
                                 32'h100 + i); end
    end
    repeat (3) @(posedge clk); #1;
    checks++; if (q0d.size() != 16)
      begin errors++; $display("FAIL skid_count got=%0d want=16", q0d.size()); end
    for (int i = 0; i < 16 && i < q0d.size(); i++) begin
      checks++;
      if (q0d[i] !== 32'h100 + i || q0l[i] !== (i == 15))
        begin errors++; $display("FAIL skid_order idx=%0d got=%h/%b want=%h/%b", i, q0d[i], q0l[i],
                                 32'h100 + i, i == 15); end
    end
  endtask

  task automatic test_skid_stall();
    q0d.delete(); q0l.delete();
    mr0 = 1'b1;
    fork
      for (int i = 0; i < 16; i++) put0(32'h200 + i, i == 15);
      begin
        repeat (4) @(posedge clk);
        #1 mr0 = 1'b0;
        checks++; if (sr0 !== 1'b1)
          begin errors++; $display("FAIL stall_sready_e0 got=%b want=1", sr0); end
        @(posedge clk); #2;
        checks++; if (sr0 !== 1'b0)
          begin errors++; $display("FAIL stall_sready_e1 got=%b want=0", sr0); end
        checks++; if (occ0 !== 4'd2)
          begin errors++; $display("FAIL stall_occ got=%0d want=2", occ0); end
        @(posedge clk); @(posedge clk); #1;
        checks++; if (sr0 !== 1'b0)
          begin errors++; $display("FAIL stall_sready_e3 got=%b want=0", sr0); end
        mr0 = 1'b1;
        @(posedge clk); #2;
        checks++; if (sr0 !== 1'b1)
          begin errors++; $display("FAIL stall_sready_e4 got=%b want=1", sr0); end
      end
    join
    repeat (4) @(posedge clk); #1;
    checks++; if (q0d.size() != 16)
      begin errors++; $display("FAIL stall_count got=%0d want=16", q0d.size()); end
    for (int i = 0; i < 16 && i < q0d.size(); i++) begin
      checks++;
      if (q0d[i] !== 32'h200 + i)
        begin errors++; $display("FAIL stall_order idx=%0d got=%h want=%h", i, q0d[i],
                                 32'h200 + i); end
    end
  endtask

  task automatic test_fifo_packet();
    q1d.delete(); q1l.delete();
    mr1 = 1'b1;
    for (int i = 0; i < 3; i++) put1(32'h300 + i, 1'b0);
    checks++; if (mv1 !== 1'b0 || occ1 !== 4'd3 || pc1 !== 4'd0)
      begin errors++; $display("FAIL pkt_hold got=%b/%0d/%0d want=0/3/0", mv1, occ1, pc1); end
    put1(32'h303, 1'b1);
    checks++; if (mv1 !== 1'b1 || occ1 !== 4'd4 || pc1 !== 4'd1)
      begin errors++; $display("FAIL pkt_release got=%b/%0d/%0d want=1/4/1", mv1, occ1, pc1); end
    for (int k = 1; k < 4; k++) begin
      @(posedge clk); #1;
      checks++; if (mv1 !== 1'b1)
        begin errors++; $display("FAIL pkt_contig k=%0d got=%b want=1", k, mv1); end
    end
    @(posedge clk); #1;
    checks++; if (mv1 !== 1'b0 || occ1 !== 4'd0 || pc1 !== 4'd0)
      begin errors++; $display("FAIL pkt_drained got=%b/%0d/%0d want=0/0/0", mv1, occ1, pc1); end
    checks++; if (q1d.size() != 4)
      begin errors++; $display("FAIL pkt_count got=%0d want=4", q1d.size()); end
    for (int i = 0; i < 4 && i < q1d.size(); i++) begin
      checks++;
      if (q1d[i] !== 32'h300 + i || q1l[i] !== (i == 3))
        begin errors++; $display("FAIL pkt_order idx=%0d got=%h/%b want=%h/%b", i, q1d[i], q1l[i],
                                 32'h300 + i, i == 3); end
    end
  endtask

  task automatic test_fifo_full();
    q1d.delete(); q1l.delete();
    mr1 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      put1(32'h400 + i, i == 3 || i == 7);
      checks++;
      if (occ1 !== 4'(i + 1) || af1 !== (i + 1 >= 6))
        begin errors++; $display("FAIL full_fill i=%0d got=%0d/%b want=%0d/%b", i, occ1, af1,
                                 i + 1, i + 1 >= 6); end
    end
    checks++; if (sr1 !== 1'b0 || pc1 !== 4'd2 || mv1 !== 1'b1)
      begin errors++; $display("FAIL full_state got=%b/%0d/%b want=0/2/1", sr1, pc1, mv1); end
    mr1 = 1'b1;
    wait_q1(8);
    @(posedge clk); #1;
    checks++; if (occ1 !== 4'd0 || pc1 !== 4'd0 || af1 !== 1'b0)
      begin errors++; $display("FAIL full_drain got=%0d/%0d/%b want=0/0/0", occ1, pc1, af1); end
    checks++; if (q1d.size() != 8)
      begin errors++; $display("FAIL full_count got=%0d want=8", q1d.size()); end
    for (int i = 0; i < 8 && i < q1d.size(); i++) begin
      checks++;
      if (q1d[i] !== 32'h400 + i)
        begin errors++; $display("FAIL full_order idx=%0d got=%h want=%h", i, q1d[i],
                                 32'h400 + i); end
    end
  endtask

  task automatic test_fifo_cut_through();
    q1d.delete(); q1l.delete();
    mr1 = 1'b1;
    for (int i = 0; i < 12; i++) put1(32'h500 + i, i == 11);
    wait_q1(12);
    @(posedge clk); #1;
    checks++; if (q1d.size() != 12)
      begin errors++; $display("FAIL cut_count got=%0d want=12", q1d.size()); end
    for (int i = 0; i < 12 && i < q1d.size(); i++) begin
      checks++;
      if (q1d[i] !== 32'h500 + i || q1l[i] !== (i == 11))
        begin errors++; $display("FAIL cut_order idx=%0d got=%h/%b want=%h/%b", i, q1d[i], q1l[i],
                                 32'h500 + i, i == 11); end
    end
    checks++; if (mv1 !== 1'b0 || occ1 !== 4'd0 || pc1 !== 4'd0)
      begin errors++; $display("FAIL cut_idle got=%b/%0d/%0d want=0/0/0", mv1, occ1, pc1); end
  endtask

  task automatic test_reset_mid_tlp();
    q1d.delete(); q1l.delete();
    mr1 = 1'b0;
    for (int i = 0; i < 5; i++) put1(32'h600 + i, 1'b0);
    checks++; if (occ1 !== 4'd5)
      begin errors++; $display("FAIL mid_occ got=%0d want=5", occ1); end
    rst1 = 1'b0;
    #1;
    checks++; if (mv1 !== 1'b0 || occ1 !== 4'd0 || pc1 !== 4'd0 || af1 !== 1'b0)
      begin errors++; $display("FAIL mid_rst got=%b/%0d/%0d/%b want=0/0/0/0", mv1, occ1, pc1, af1);
      end
    checks++; if (sr1 !== 1'b0)
      begin errors++; $display("FAIL mid_rst_sready got=%b want=0", sr1); end
    @(posedge clk); @(posedge clk); #1;
    checks++; if (sr1 !== 1'b0)
      begin errors++; $display("FAIL mid_held_sready got=%b want=0", sr1); end
    rst1 = 1'b1;
    @(posedge clk); #1;
    checks++; if (sr1 !== 1'b1 || mv1 !== 1'b0)
      begin errors++; $display("FAIL mid_release got=%b/%b want=1/0", sr1, mv1); end
    mr1 = 1'b1;
    for (int i = 0; i < 3; i++) put1(32'h700 + i, i == 2);
    wait_q1(3);
    @(posedge clk); #1;
    checks++; if (q1d.size() != 3)
      begin errors++; $display("FAIL mid_next_count got=%0d want=3", q1d.size()); end
    for (int i = 0; i < 3 && i < q1d.size(); i++) begin
      checks++;
      if (q1d[i] !== 32'h700 + i || q1l[i] !== (i == 2))
        begin errors++; $display("FAIL mid_next_order idx=%0d got=%h/%b want=%h/%b", i, q1d[i],
                                 q1l[i], 32'h700 + i, i == 2); end
    end
  endtask

  task automatic test_bypass();
    sv2 = 1'b1; sd2 = 32'hABCD_1234; sl2 = 1'b1; su2 = 10'h2A5; mr2 = 1'b0;
    #1;
    checks++; if (mv2 !== 1'b1 || md2 !== 32'hABCD_1234 || ml2 !== 1'b1 || mu2 !== 10'h2A5)
      begin errors++; $display("FAIL byp_fwd got=%b/%h/%b/%h want=1/abcd1234/1/2a5", mv2, md2, ml2,
                               mu2); end
    checks++; if (sr2 !== 1'b0)
      begin errors++; $display("FAIL byp_ready_lo got=%b want=0", sr2); end
    mr2 = 1'b1; sl2 = 1'b0; sd2 = 32'h0000_5555;
    #1;
    checks++; if (sr2 !== 1'b1 || md2 !== 32'h0000_5555 || ml2 !== 1'b0)
      begin errors++; $display("FAIL byp_ready_hi got=%b/%h/%b want=1/00005555/0", sr2, md2, ml2);
      end
    @(posedge clk); #1;
    checks++; if (occ2 !== 4'd0 || pc2 !== 4'd0 || af2 !== 1'b0)
      begin errors++; $display("FAIL byp_stat got=%0d/%0d/%b want=0/0/0", occ2, pc2, af2); end
    sv2 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_skid_stream();
    test_skid_stall();
    test_fifo_packet();
    test_fifo_full();
    test_fifo_cut_through();
    test_reset_mid_tlp();
    test_bypass();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
